scaler_param_loader: RTL and testbench
======================================

# scaler_param_loader

Streaming loader that fills the per-channel scale and shift registers of the output scaler set from a packed 32-bit word stream. It sits between the configuration DMA / CSR write path and the scaler set. It unpacks each accepted word into one-element-per-cycle write strobes. It always emits exactly numElements scale writes followed by numElements shift writes, so the scaler set's free-running write address counters end each load back at 0.

## Interface
- numElements, 64: scaler channels per load; power of two; multiple of busWidth/scaleBits and of busWidth/shiftBits
- busWidth, 32: input stream word width
- scaleBits, 16: scale field width; must divide busWidth
- shiftBits, 4: shift field width; must divide busWidth
- clk  in  1  clock; reset nrst, asynchronous, active-low; clock clk
- nrst  in  1  asynchronous active-low reset
- start_i  in  1  one-cycle load request; honoured only in IDLE
- in_valid_i  in  1  stream word valid
- in_ready_o  out  1  stream word accepted when valid&ready at posedge
- in_data_i  in  busWidth  packed parameter word, lane 0 in LSBs
- scale_w_en_o  out  1  scale write strobe, one element per cycle
- scale_w_data_o  out  scaleBits  scale value, raw bits
- shift_w_en_o  out  1  shift write strobe
- shift_w_data_o  out  shiftBits  shift value, raw bits
- busy_o  out  1  high from leaving IDLE until return to IDLE
- done_o  out  1  one-cycle pulse after the final shift write

## Operation
- Derived constants: SPW = busWidth/scaleBits (2), HPW = busWidth/shiftBits (8).
- Words per phase: numElements/SPW scale words (32), then numElements/HPW shift words (8).
- FSM states and transitions:
  - IDLE: start_i=1 -> SCALE.
  - SCALE: when the numElements-th scale write is issued -> SHIFT.
  - SHIFT: when the numElements-th shift write is issued -> DONE.
  - DONE: one cycle, done_o=1 -> IDLE.
- Unpack buffer: one word register, lane index, buf_valid.
  - On accept: buffer <= in_data_i, lane <= 0, buf_valid <= 1.
  - Each cycle buf_valid=1: emit lane `lane` (bits [lane*W +: W]) to the registered write outputs with its strobe high, then increment lane.
  - After the last lane, buf_valid clears unless a new word is accepted on the same edge.
- in_ready_o = state∈{SCALE,SHIFT} and words remaining in the current phase > 0 and (!buf_valid or lane == last lane). This allows back-to-back words at full rate.
- No word is accepted in SCALE once all scale words have been taken. The first shift word is accepted only in SHIFT.
- Element counter counts issued writes per phase and clears on phase change.
- Fields pass through unmodified; no sign extension or saturation.
- start_i outside IDLE is ignored. in_data_i is ignored unless a handshake occurs.
- scale_w_en_o and shift_w_en_o are never high in the same cycle.

## Timing
- Reset values: in_ready_o=0, scale_w_en_o=0, scale_w_data_o=0, shift_w_en_o=0, shift_w_data_o=0, busy_o=0, done_o=0; FSM in IDLE, buffer empty, counters 0.
- start_i sampled at edge k: state=SCALE and busy_o=1 after k; in_ready_o high in cycle k+1.
- Word accepted at edge a: its lane 0 strobe is high during cycle a+1→a+2; lane j follows at a+1+j.
- Sustained throughput with in_valid_i held high: 1 write/cycle in both phases.
- Phase change costs exactly one bubble cycle with no strobe. The first shift word is accepted on the edge after SHIFT is entered.
- done_o is high for the single cycle after the cycle holding the last shift strobe. busy_o falls together with done_o's deassertion.
- in_valid_i gaps insert strobe-free cycles; no data loss or duplication.
- nrst mid-load: all state and outputs return to reset values immediately. The partial load is discarded, and the downstream scaler set must also be reset before reloading.

## Test plan
- Full load, numElements=64, continuous stream:
  - Scale word w = {16'(2w+1), 16'(2w)}; shift words carry nibble i = i mod 16.
  - Required: 64 scale strobes with data 0..63 in order, then one bubble, then 64 shift strobes with data i mod 16.
  - done_o pulses once; total cycles from start ≈ 131.
- Backpressure: drop in_valid_i for 3 cycles after every 5th word -> identical strobe data sequence; strobe count 64+64; no duplicates.
- start_i pulsed during SCALE and during DONE -> ignored; exactly one load occurs; busy_o never glitches low mid-load.
- Extra words offered after the 32nd scale word while still in SCALE -> in_ready_o=0 until SHIFT; the 33rd word becomes shift word 0.
- Assert nrst for 1 cycle after 20 scale writes -> all outputs 0. A fresh start then performs a complete, correct 128-write load.
- Back-to-back loads: start_i asserted the cycle after done_o -> second load begins; strobe sequences match the first load.

Source files
------------

// File: rtl/scaler_param_loader_if.sv
// Stream of packed parameter words feeding the loader.
// valid/ready handshake; lane 0 sits in the data LSBs.
interface scaler_param_loader_if #(
  parameter int W = 32
) ();
  logic         valid;
  logic         ready;
  logic [W-1:0] data;

  modport master (
    output valid,
    output data,
    input  ready
  );

  modport slave (
    input  valid,
    input  data,
    output ready
  );
endinterface

// File: rtl/scaler_param_loader.sv
// Unpacks packed words into one-per-cycle scale writes,
// then shift writes, for the output scaler set.
module scaler_param_loader #(
  parameter int NUM_ELEMENTS = 64,
  parameter int BUS_WIDTH    = 32,
  parameter int SCALE_BITS   = 16,
  parameter int SHIFT_BITS   = 4
) (
  input  logic                  clk,
  input  logic                  nrst,
  input  logic                  start_i,
  scaler_param_loader_if.slave  in_s,
  output logic                  scale_w_en_o,
  output logic [SCALE_BITS-1:0] scale_w_data_o,
  output logic                  shift_w_en_o,
  output logic [SHIFT_BITS-1:0] shift_w_data_o,
  output logic                  busy_o,
  output logic                  done_o
);

  localparam int SPW  = BUS_WIDTH / SCALE_BITS;
  localparam int HPW  = BUS_WIDTH / SHIFT_BITS;
  localparam int MAXL = (SPW > HPW) ? SPW : HPW;
  localparam int LW   = (MAXL > 1) ? $clog2(MAXL) : 1;
  localparam int EW   =
    (NUM_ELEMENTS > 1) ? $clog2(NUM_ELEMENTS) : 1;
  localparam int WW   = $clog2(NUM_ELEMENTS + 1);

  localparam logic [WW-1:0] SCALE_WORDS =
    WW'(NUM_ELEMENTS / SPW);
  localparam logic [WW-1:0] SHIFT_WORDS =
    WW'(NUM_ELEMENTS / HPW);
  localparam logic [EW-1:0] LAST_ELEM  = EW'(NUM_ELEMENTS - 1);
  localparam logic [LW-1:0] SCALE_LAST = LW'(SPW - 1);
  localparam logic [LW-1:0] SHIFT_LAST = LW'(HPW - 1);

  typedef enum logic [1:0] {
    IDLE,
    SCALE,
    SHIFT,
    DONE
  } state_t;

  state_t                state_q, state_d;
  logic [BUS_WIDTH-1:0]  buf_q, buf_d;
  logic                  buf_valid_q, buf_valid_d;
  logic [LW-1:0]         lane_q, lane_d;
  logic [EW-1:0]         elem_q, elem_d;
  logic [WW-1:0]         words_q, words_d;
  logic                  scale_en_q, scale_en_d;
  logic [SCALE_BITS-1:0] scale_data_q, scale_data_d;
  logic                  shift_en_q, shift_en_d;
  logic [SHIFT_BITS-1:0] shift_data_q, shift_data_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;

  logic                  in_phase;
  logic                  last_lane;
  logic [WW-1:0]         phase_words;
  logic                  ready;
  logic                  accept;
  logic                  emit;

  // Handshake: take a word only when the buffer frees up this edge.
  always_comb begin
    in_phase    = (state_q == SCALE) || (state_q == SHIFT);
    last_lane   = (state_q == SHIFT) ? (lane_q == SHIFT_LAST)
                                     : (lane_q == SCALE_LAST);
    phase_words = (state_q == SHIFT) ? SHIFT_WORDS : SCALE_WORDS;
    ready       = in_phase && (words_q != phase_words) &&
                  (!buf_valid_q || last_lane);
    accept      = in_s.valid && ready;
    emit        = in_phase && buf_valid_q;
  end

  assign in_s.ready = ready;

  // Unpack lanes, count elements, and sequence the phases.
  always_comb begin
    state_d      = state_q;
    buf_d        = buf_q;
    buf_valid_d  = buf_valid_q;
    lane_d       = lane_q;
    elem_d       = elem_q;
    words_d      = words_q;
    scale_en_d   = 1'b0;
    scale_data_d = scale_data_q;
    shift_en_d   = 1'b0;
    shift_data_d = shift_data_q;
    done_d       = (state_q == DONE);

    if (emit) begin
      if (state_q == SCALE) begin
        scale_en_d   = 1'b1;
        scale_data_d = SCALE_BITS'(
          buf_q >> (int'(lane_q) * SCALE_BITS));
      end else begin
        shift_en_d   = 1'b1;
        shift_data_d = SHIFT_BITS'(
          buf_q >> (int'(lane_q) * SHIFT_BITS));
      end
      if (last_lane) begin
        buf_valid_d = 1'b0;
        lane_d      = '0;
      end else begin
        lane_d = lane_q + 1'b1;
      end
      elem_d = elem_q + 1'b1;
    end

    if (accept) begin
      buf_d       = in_s.data;
      buf_valid_d = 1'b1;
      lane_d      = '0;
      words_d     = words_q + 1'b1;
    end

    unique case (1'b1)
      state_q == IDLE: begin
        if (start_i) state_d = SCALE;
      end
      state_q == SCALE: begin
        if (emit && elem_q == LAST_ELEM) begin
          state_d = SHIFT;
          elem_d  = '0;
          words_d = '0;
        end
      end
      state_q == SHIFT: begin
        if (emit && elem_q == LAST_ELEM) begin
          state_d = DONE;
          elem_d  = '0;
          words_d = '0;
        end
      end
      state_q == DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // busy stays up through the done pulse.
    busy_d = (state_d != IDLE) || done_d;
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q      <= IDLE;
      buf_q        <= '0;
      buf_valid_q  <= 1'b0;
      lane_q       <= '0;
      elem_q       <= '0;
      words_q      <= '0;
      scale_en_q   <= 1'b0;
      scale_data_q <= '0;
      shift_en_q   <= 1'b0;
      shift_data_q <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      buf_q        <= buf_d;
      buf_valid_q  <= buf_valid_d;
      lane_q       <= lane_d;
      elem_q       <= elem_d;
      words_q      <= words_d;
      scale_en_q   <= scale_en_d;
      scale_data_q <= scale_data_d;
      shift_en_q   <= shift_en_d;
      shift_data_q <= shift_data_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign scale_w_en_o   = scale_en_q;
  assign scale_w_data_o = scale_data_q;
  assign shift_w_en_o   = shift_en_q;
  assign shift_w_data_o = shift_data_q;
  assign busy_o         = busy_q;
  assign done_o         = done_q;

endmodule

// File: tb/tb_scaler_param_loader.sv
// Scoreboard bench for scaler_param_loader: loads are queued
// as expected strobes, a negedge monitor pops and compares.
module tb_scaler_param_loader;

  localparam int N   = 64;
  localparam int BW  = 32;
  localparam int SB  = 16;
  localparam int HB  = 4;
  localparam int SPW = BW / SB;
  localparam int HPW = BW / HB;
  localparam int NSW = N / SPW;
  localparam int NHW = N / HPW;
  localparam int NW  = NSW + NHW;
  localparam int LIMIT = 2000;

  logic          clk = 1'b0;
  logic          nrst = 1'b0;
  logic          start_i = 1'b0;
  logic          scale_w_en_o;
  logic [SB-1:0] scale_w_data_o;
  logic          shift_w_en_o;
  logic [HB-1:0] shift_w_data_o;
  logic          busy_o;
  logic          done_o;

  scaler_param_loader_if #(.W(BW)) in_if ();

  scaler_param_loader #(
    .NUM_ELEMENTS(N),
    .BUS_WIDTH(BW),
    .SCALE_BITS(SB),
    .SHIFT_BITS(HB)
  ) dut (
    .clk(clk),
    .nrst(nrst),
    .start_i(start_i),
    .in_s(in_if.slave),
    .scale_w_en_o(scale_w_en_o),
    .scale_w_data_o(scale_w_data_o),
    .shift_w_en_o(shift_w_en_o),
    .shift_w_data_o(shift_w_data_o),
    .busy_o(busy_o),
    .done_o(done_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        is_shift;
    logic [15:0] data;
  } exp_t;

  exp_t exp_q[$];
  exp_t e;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int n_seen, n_scale, n_shift;
  int start_cyc, last_scale_cyc, first_shift_cyc;
  bit in_load = 0;
  bit load_done = 0;
  bit cont_chk = 0;
  bit prev_done = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  task automatic fail(input string name, input string what);
    checks++;
    errors++;
    $display("FAIL %s: %s", name, what);
  endtask

  function automatic void push_exp(input bit s, input int d);
    exp_t x;
    x.is_shift = s;
    x.data     = 16'(d);
    exp_q.push_back(x);
  endfunction

  // Monitor: compare every strobe against the scoreboard.
  always @(negedge clk) begin
    if (!nrst) begin
      prev_done = 1'b0;
    end else begin
      if (scale_w_en_o || shift_w_en_o) begin
        chk("strobe_excl",
            32'(scale_w_en_o & shift_w_en_o), 32'd0);
        if (exp_q.size() == 0) begin
          fail("unexpected_strobe",
               "got a write strobe, expected none");
        end else begin
          e = exp_q.pop_front();
          chk("strobe_kind", 32'(shift_w_en_o),
              32'(e.is_shift));
          chk("strobe_data",
              shift_w_en_o ? 32'(shift_w_data_o)
                           : 32'(scale_w_data_o),
              32'(e.data));
        end
        n_seen++;
        if (scale_w_en_o) begin
          n_scale++;
          last_scale_cyc = cyc;
        end else begin
          if (n_shift == 0) first_shift_cyc = cyc;
          n_shift++;
        end
      end
      if (in_load && !load_done && cyc >= start_cyc)
        chk("busy_high", 32'(busy_o), 32'd1);
      if (prev_done)
        chk("busy_fall", 32'(busy_o), 32'd0);
      if (done_o) begin
        if (!in_load) begin
          fail("spurious_done", "got done_o, expected none");
        end else begin
          chk("done_drain", 32'(exp_q.size()), 32'd0);
          chk("strobe_count", 32'(n_seen), 32'(2 * N));
          if (cont_chk) begin
            chk("latency", 32'(cyc - start_cyc), 32'd131);
            chk("bubble", 32'(first_shift_cyc - last_scale_cyc),
                32'd2);
          end
          load_done = 1'b1;
        end
      end
      prev_done = done_o;
    end
  end

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_ready"}, 32'(in_if.ready), 32'd0);
    chk({tag, "_scale_en"}, 32'(scale_w_en_o), 32'd0);
    chk({tag, "_scale_data"}, 32'(scale_w_data_o), 32'd0);
    chk({tag, "_shift_en"}, 32'(shift_w_en_o), 32'd0);
    chk({tag, "_shift_data"}, 32'(shift_w_data_o), 32'd0);
    chk({tag, "_busy"}, 32'(busy_o), 32'd0);
    chk({tag, "_done"}, 32'(done_o), 32'd0);
  endtask

  // gap_mode: 0 continuous, 1 3-cycle gap every 5th word,
  // 2 random gaps.  mode: 0 test pattern, 1 random words.
  task automatic run_load(input int mode, input int gap_mode,
                          input bit pulses, input int abort_at,
                          input bit cont);
    logic [BW-1:0] words[NW];
    int idx = 0;
    int gapc = 0;
    int t = 0;
    bit fin = 0;

    if (mode == 0) begin
      for (int w = 0; w < NSW; w++)
        words[w] = {16'(2 * w + 1), 16'(2 * w)};
      for (int k = 0; k < NHW; k++) begin
        words[NSW + k] = '0;
        for (int j = 0; j < HPW; j++)
          words[NSW + k][j * HB +: HB] = HB'((k * HPW + j) % 16);
      end
      for (int i = 0; i < N; i++) push_exp(1'b0, i);
      for (int i = 0; i < N; i++) push_exp(1'b1, i % 16);
    end else begin
      for (int w = 0; w < NW; w++) words[w] = $urandom;
      for (int w = 0; w < NSW; w++)
        for (int l = 0; l < SPW; l++)
          push_exp(1'b0, int'((words[w] >> (l * SB)) & 32'hFFFF));
      for (int w = 0; w < NHW; w++)
        for (int l = 0; l < HPW; l++)
          push_exp(1'b1,
                   int'((words[NSW + w] >> (l * HB)) & 32'hF));
    end

    n_seen = 0;
    n_scale = 0;
    n_shift = 0;
    load_done = 1'b0;
    cont_chk = cont;

    @(negedge clk);
    #1;
    start_i = 1'b1;
    start_cyc = cyc + 1;
    in_load = 1'b1;

    while (!fin) begin
      @(negedge clk);
      #1;
      t++;
      start_i = 1'b0;
      if (load_done) begin
        fin = 1;
      end else if (t > LIMIT) begin
        fail("timeout", "load did not complete in cycle budget");
        exp_q.delete();
        fin = 1;
      end else if (abort_at > 0 && n_scale >= abort_at) begin
        nrst = 1'b0;
        in_if.valid = 1'b0;
        in_load = 1'b0;
        exp_q.delete();
        #1;
        check_reset_outputs("midreset");
        @(negedge clk);
        #1;
        nrst = 1'b1;
        fin = 1;
      end else begin
        if (pulses && (n_scale == 10 || n_seen == 2 * N))
          start_i = 1'b1;
        if (gapc > 0) begin
          in_if.valid = 1'b0;
          in_if.data = $urandom;
          gapc--;
        end else if (idx < NW &&
                     (gap_mode != 2 || $urandom_range(0, 3) != 0)) begin
          in_if.valid = 1'b1;
          in_if.data = words[idx];
        end else begin
          in_if.valid = 1'b0;
          in_if.data = $urandom;
        end
        if (idx == NSW && n_scale < N)
          chk("early_shift_ready", 32'(in_if.ready), 32'd0);
        if (in_if.valid && in_if.ready) begin
          idx++;
          if (gap_mode == 1 && idx % 5 == 0) gapc = 3;
        end
      end
    end
    in_if.valid = 1'b0;
    in_load = 1'b0;
  endtask

  task automatic idle_check(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
      chk("idle_busy", 32'(busy_o), 32'd0);
    end
  endtask

  initial begin
    in_if.valid = 1'b0;
    in_if.data = '0;
    repeat (2) @(negedge clk);
    #1;
    check_reset_outputs("reset");
    nrst = 1'b1;
    @(negedge clk);
    #1;
    check_reset_outputs("post_reset");

    run_load(0, 0, 0, 0, 1);
    run_load(0, 1, 0, 0, 0);
    run_load(1, 0, 1, 0, 1);
    idle_check(5);
    run_load(0, 0, 0, 20, 0);
    idle_check(2);
    run_load(0, 0, 0, 0, 1);
    run_load(1, 0, 0, 0, 1);
    run_load(1, 0, 0, 0, 1);
    run_load(1, 2, 0, 0, 0);
    run_load(1, 1, 0, 0, 0);
    idle_check(3);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
